tug_input_cond: RTL

Conditions the two raw player push-buttons for the tug-of-war game core. Each button is synchronised and debounced against the 1-in-64 slow enable strobe. Each clean press becomes a single-clock pulse. A short post-press lockout is applied, and same-tick presses are reported as a tie. The block sits between the board buttons and the divide-by-64 enable generator upstream, and the rope-position state machine downstream.

---
 rtl/tug_input_cond_pkg.sv | 17 +
 rtl/tug_debounce_chan.sv | 65 ++++++
 rtl/tug_input_cond.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tug_input_cond_pkg.sv
// Shared tug-of-war game definitions: arbitration states and timing defaults.
package tug_input_cond_pkg;

  // Arbitration FSM states.
  typedef enum logic [0:0] {
    StReady,
    StLocked
  } arb_state_e;

  // Default number of consecutive slow ticks a changed button level must hold.
  localparam int unsigned DefDebounceTicks = 4;
  // Default number of slow ticks both channels stay locked after an event.
  localparam int unsigned DefLockTicks     = 2;
  // Period of the upstream slow enable strobe, in clk cycles.
  localparam int unsigned SlowTickPeriod   = 64;

endpackage

// File: rtl/tug_debounce_chan.sv
// One button channel: 2-FF synchroniser plus slow-tick debounce with a rise strobe.
module tug_debounce_chan
  import tug_input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_en_i,
  input  logic btn_i,
  output logic st_o,
  output logic rise_o
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS - 1);

  logic [1:0]      sync_q;
  logic            sync;
  logic            st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign sync = sync_q[1];
  assign st_o = st_q;

  // Synchronise the asynchronous button every clk, independent of the slow tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // A differing level must persist for DEBOUNCE_TICKS consecutive ticks to be adopted;
  // rise_o flags the tick on which the stable level goes high.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rise_o = 1'b0;
    if (slow_en_i) begin
      if (sync == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        st_d   = sync;
        cnt_d  = '0;
        rise_o = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tug_input_cond.sv
// Player button conditioner: two debounced channels, press arbitration with tie
// detection and a post-event lockout, all outputs registered.
module tug_input_cond
  import tug_input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DefDebounceTicks,
  parameter int unsigned LOCK_TICKS     = DefLockTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_en_i,
  input  logic game_active_i,
  input  logic btn_l_i,
  input  logic btn_r_i,
  output logic pls_l_o,
  output logic pls_r_o,
  output logic tie_o,
  output logic locked_o
);

  localparam int unsigned      LockW   = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_TICKS - 1);

  logic             st_l, st_r;
  logic             rise_l, rise_r;
  logic             evt_any, accept;
  arb_state_e       state_q, state_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             pls_l_q, pls_l_d;
  logic             pls_r_q, pls_r_d;
  logic             tie_q, tie_d;
  logic             locked_q, locked_d;

  tug_debounce_chan #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_chan_l (
    .clk      (clk),
    .rst      (rst),
    .slow_en_i(slow_en_i),
    .btn_i    (btn_l_i),
    .st_o     (st_l),
    .rise_o   (rise_l)
  );

  tug_debounce_chan #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_chan_r (
    .clk      (clk),
    .rst      (rst),
    .slow_en_i(slow_en_i),
    .btn_i    (btn_r_i),
    .st_o     (st_r),
    .rise_o   (rise_r)
  );

  // Rise strobes are already qualified by slow_en.
  assign evt_any = rise_l | rise_r;

  // The lock-expiry tick is judged as READY, so a press completing on it is taken.
  assign accept = slow_en_i & game_active_i &
                  ((state_q == StReady) | (lock_cnt_q == '0));

  // State, lock counter and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReady;
      lock_cnt_q <= '0;
      pls_l_q    <= 1'b0;
      pls_r_q    <= 1'b0;
      tie_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      pls_l_q    <= pls_l_d;
      pls_r_q    <= pls_r_d;
      tie_q      <= tie_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state: advance only on the slow tick; an inactive game forces READY.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (slow_en_i) begin
      if (!game_active_i) begin
        state_d    = StReady;
        lock_cnt_d = '0;
      end else begin
        unique case (state_q)
          StReady: begin
            if (evt_any) begin
              state_d    = StLocked;
              lock_cnt_d = LockMax;
            end
          end
          StLocked: begin
            if (lock_cnt_q == '0) begin
              if (evt_any) begin
                state_d    = StLocked;
                lock_cnt_d = LockMax;
              end else begin
                state_d = StReady;
              end
            end else begin
              lock_cnt_d = lock_cnt_q - 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Outputs: single-channel events pulse their channel, simultaneous events pulse tie only.
  always_comb begin
    pls_l_d  = accept & rise_l & ~rise_r;
    pls_r_d  = accept & rise_r & ~rise_l;
    tie_d    = accept & rise_l & rise_r;
    locked_d = (state_d == StLocked);
  end

  assign pls_l_o  = pls_l_q;
  assign pls_r_o  = pls_r_q;
  assign tie_o    = tie_q;
  assign locked_o = locked_q;

  // A rise strobe always leaves the stable level high on the following cycle.
  a_rise_l_st : assert property (@(posedge clk) disable iff (rst) rise_l |=> st_l);
  a_rise_r_st : assert property (@(posedge clk) disable iff (rst) rise_r |=> st_r);

endmodule
